// File: rtl/countdown_timer_pkg.sv
// rtl/countdown_timer_pkg.sv - state encoding and width default for countdown_timer32
package countdown_timer_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides qualified enable cycles into count ticks
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_enable,
    input  logic i_clear,
    input  logic i_hold,
    output logic o_tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          wrap;

    assign wrap   = (pre_q == PW'(PRESCALE - 1));
    assign o_tick = i_enable && !i_hold && wrap;

    // Hold freezes the phase so a resumed run continues mid-interval.
    always_comb begin
        pre_d = pre_q;
        if (i_clear) begin
            pre_d = '0;
        end else if (i_enable && !i_hold) begin
            pre_d = wrap ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/countdown_timer32.sv
// rtl/countdown_timer32.sv - programmable down-counter with pause, auto-reload and expiry pulse
module countdown_timer32
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int PRESCALE = 1
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic             i_auto_reload,
    output logic [WIDTH-1:0] o_count,
    output logic             o_expired,
    output logic             o_busy,
    output logic [1:0]       o_state
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expired_q, expired_d;
    logic             pre_clear;
    logic             pre_hold;
    logic             tick;

    // Prescaler only advances while running and not being paused this cycle.
    assign pre_hold = (state_q != ST_RUN) || i_pause;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_enable (i_enable),
        .i_clear  (pre_clear),
        .i_hold   (pre_hold),
        .o_tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        expired_d = 1'b0;
        pre_clear = 1'b0;
        if (i_load) begin
            count_d   = i_load_value;
            reload_d  = i_load_value;
            state_d   = ST_IDLE;
            pre_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!i_pause && i_start && count_q != '0) begin
                        state_d   = ST_RUN;
                        pre_clear = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_pause) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        if (count_q == WIDTH'(1)) begin
                            expired_d = 1'b1;
                            if (i_auto_reload && reload_q != '0) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_DONE;
                            end
                        end else if (count_q != '0) begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!i_pause && i_start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (!i_pause && i_start && reload_q != '0) begin
                        count_d   = reload_q;
                        state_d   = ST_RUN;
                        pre_clear = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            expired_q <= expired_d;
        end
    end

    assign o_count   = count_q;
    assign o_expired = expired_q;
    assign o_busy    = (state_q == ST_RUN);
    assign o_state   = state_q;

endmodule
